// File: rtl/avalonmem_rx_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : avalonmem_rx_capture_ctrl
// Brief   : Capture-window write controller for the RX result memory; two
//           producers share one write port through round-robin arbitration.
// Revision: 1.0 - initial release
// ============================================================================
module avalonmem_rx_capture_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int WRAP_MODE = 0
) (
    input  logic              MEM_CLK,
    input  logic              MEM_RESET,
    input  logic              START,
    input  logic              ABORT,
    input  logic [ADDR_W:0]   LENGTH,
    input  logic              A_VALID,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_READY,
    input  logic              B_VALID,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic              MEM_WREN,
    output logic              BUSY,
    output logic              DONE,
    output logic              WRAPPED,
    output logic [ADDR_W:0]   WORD_COUNT
);

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_CAPTURE = 2'd1;
    localparam logic [1:0] C_DONE    = 2'd2;

    localparam logic [ADDR_W:0] C_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_last_b;
    logic              r_wrapped;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_wren;

    logic              w_active;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_grant;
    logic [ADDR_W:0]   w_len_eff;
    logic [ADDR_W:0]   w_len_m1;
    logic              w_terminal;

    // Grants are suppressed in the START/ABORT cycle so no write can slip past a restart.
    always_comb begin
        w_active  = (r_state == C_CAPTURE) && !START && !ABORT;
        w_grant_a = w_active && A_VALID && (!B_VALID || r_last_b);
        w_grant_b = w_active && B_VALID && (!A_VALID || !r_last_b);
        w_grant   = w_grant_a || w_grant_b;
        w_len_eff = (r_len == '0) ? C_FULL : r_len;
        w_len_m1  = w_len_eff - 1'b1;
        // Wrap mode tracks the pointer because the count saturates after the first pass.
        if (WRAP_MODE != 0) begin
            w_terminal = ({1'b0, r_wr_ptr} == w_len_m1);
        end else begin
            w_terminal = (r_count == w_len_m1);
        end
    end

    always_ff @(posedge MEM_CLK or posedge MEM_RESET) begin
        if (MEM_RESET) begin
            r_state    <= C_IDLE;
            r_len      <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_last_b   <= 1'b1;
            r_wrapped  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_wren <= 1'b0;
        end else begin
            r_mem_wren <= w_grant;
            if (w_grant) begin
                r_mem_addr <= r_wr_ptr;
                r_mem_data <= w_grant_a ? A_DATA : B_DATA;
                r_last_b   <= w_grant_b;
                if (r_count != w_len_eff) begin
                    r_count <= r_count + 1'b1;
                end
                if (w_terminal) begin
                    if (WRAP_MODE != 0) begin
                        r_wr_ptr  <= '0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_state  <= C_DONE;
                    end
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end

            if (ABORT) begin
                r_state <= C_IDLE;
            end else if (START) begin
                r_state   <= C_CAPTURE;
                r_len     <= LENGTH;
                r_wr_ptr  <= '0;
                r_count   <= '0;
                r_wrapped <= 1'b0;
            end
        end
    end

    assign A_READY    = w_grant_a;
    assign B_READY    = w_grant_b;
    assign MEM_ADDR   = r_mem_addr;
    assign MEM_DATA   = r_mem_data;
    assign MEM_WREN   = r_mem_wren;
    assign BUSY       = (r_state == C_CAPTURE);
    assign DONE       = (r_state == C_DONE);
    assign WRAPPED    = r_wrapped;
    assign WORD_COUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_avalonmem_rx_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_avalonmem_rx_capture_ctrl
// Brief   : Directed self-checking bench; a stop-mode and a wrap-mode instance
//           share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_avalonmem_rx_capture_ctrl;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, abort;
    logic [ADDR_W:0]   length;
    logic              a_valid, b_valid;
    logic [DATA_W-1:0] a_data, b_data;

    logic              a_ready, b_ready, wren, busy, done, wrapped;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W:0]   wcount;

    logic              w_a_ready, w_b_ready, w_wren, w_busy, w_done, w_wrapped;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W:0]   w_wcount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avalonmem_rx_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRAP_MODE(0)) u_dut (
        .MEM_CLK(clk), .MEM_RESET(rst), .START(start), .ABORT(abort), .LENGTH(length),
        .A_VALID(a_valid), .A_DATA(a_data), .A_READY(a_ready),
        .B_VALID(b_valid), .B_DATA(b_data), .B_READY(b_ready),
        .MEM_ADDR(addr), .MEM_DATA(data), .MEM_WREN(wren),
        .BUSY(busy), .DONE(done), .WRAPPED(wrapped), .WORD_COUNT(wcount)
    );

    avalonmem_rx_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRAP_MODE(1)) u_dut_wrap (
        .MEM_CLK(clk), .MEM_RESET(rst), .START(start), .ABORT(abort), .LENGTH(length),
        .A_VALID(a_valid), .A_DATA(a_data), .A_READY(w_a_ready),
        .B_VALID(b_valid), .B_DATA(b_data), .B_READY(w_b_ready),
        .MEM_ADDR(w_addr), .MEM_DATA(w_data), .MEM_WREN(w_wren),
        .BUSY(w_busy), .DONE(w_done), .WRAPPED(w_wrapped), .WORD_COUNT(w_wcount)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; abort = 0; a_valid = 0; b_valid = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic do_start(input logic [ADDR_W:0] len);
        start  = 1;
        length = len;
        tick();
        start  = 0;
    endtask

    initial begin
        length = '0; a_data = '0; b_data = '0;
        do_reset();

        // Reset state
        check("rst_wren",   {63'd0, wren},    64'd0);
        check("rst_addr",   {55'd0, addr},    64'd0);
        check("rst_data",   {32'd0, data},    64'd0);
        check("rst_busy",   {63'd0, busy},    64'd0);
        check("rst_done",   {63'd0, done},    64'd0);
        check("rst_wrap",   {63'd0, wrapped}, 64'd0);
        check("rst_count",  {54'd0, wcount},  64'd0);
        check("rst_aready", {63'd0, a_ready}, 64'd0);

        // Test 1: asynchronous reset in the middle of a capture
        do_start(10'd8);
        a_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_data = 32'h50 + i;
            tick();
        end
        check("t1_pre_count", {54'd0, wcount}, 64'd3);
        #2 rst = 1;
        #1;
        check("t1_async_wren",  {63'd0, wren},   64'd0);
        check("t1_async_busy",  {63'd0, busy},   64'd0);
        check("t1_async_addr",  {55'd0, addr},   64'd0);
        check("t1_async_data",  {32'd0, data},   64'd0);
        check("t1_async_count", {54'd0, wcount}, 64'd0);
        tick();
        rst = 0;
        tick();
        do_start(10'd8);
        a_data = 32'h77;
        tick();
        check("t1_restart_wren", {63'd0, wren}, 64'd1);
        check("t1_restart_addr", {55'd0, addr}, 64'd0);
        check("t1_restart_data", {32'd0, data}, 64'h77);

        // Test 2: LENGTH=4, A streams 0x10..0x13
        do_reset();
        a_valid = 1;
        do_start(10'd4);
        for (int i = 0; i < 4; i++) begin
            a_data = 32'h10 + i;
            #1;
            check("t2_aready", {63'd0, a_ready}, 64'd1);
            tick();
            check("t2_wren", {63'd0, wren}, 64'd1);
            check("t2_addr", {55'd0, addr}, 64'(i));
            check("t2_data", {32'd0, data}, 64'(32'h10 + i));
        end
        check("t2_done",     {63'd0, done},    64'd1);
        check("t2_busy",     {63'd0, busy},    64'd0);
        check("t2_count",    {54'd0, wcount},  64'd4);
        check("t2_aready_0", {63'd0, a_ready}, 64'd0);
        tick();
        check("t2_no_5th",   {63'd0, wren},    64'd0);
        check("t2_done_hold",{63'd0, done},    64'd1);

        // Test 3: both valid, LENGTH=6 -> A,B,A,B,A,B
        do_reset();
        begin
            int na = 0, nb = 0;
            a_valid = 1; b_valid = 1;
            do_start(10'd6);
            for (int i = 0; i < 6; i++) begin
                logic exp_a;
                exp_a  = (i % 2 == 0);
                a_data = 32'hA00 + na;
                b_data = 32'hB00 + nb;
                #1;
                check("t3_aready", {63'd0, a_ready}, {63'd0, exp_a});
                check("t3_bready", {63'd0, b_ready}, {63'd0, !exp_a});
                tick();
                check("t3_addr", {55'd0, addr}, 64'(i));
                check("t3_data", {32'd0, data}, exp_a ? 64'(32'hA00 + na) : 64'(32'hB00 + nb));
                if (exp_a) na++; else nb++;
            end
            check("t3_done", {63'd0, done}, 64'd1);
            tick();
            check("t3_no_7th", {63'd0, wren}, 64'd0);
        end

        // Test 4: wrap mode, LENGTH=3, 5 words
        do_reset();
        b_valid = 0;
        a_valid = 1;
        do_start(10'd3);
        for (int i = 0; i < 5; i++) begin
            a_data = 32'h20 + i;
            tick();
            check("t4_wren", {63'd0, w_wren}, 64'd1);
            check("t4_addr", {55'd0, w_addr}, 64'(i % 3));
            check("t4_data", {32'd0, w_data}, 64'(32'h20 + i));
            if (i >= 3) check("t4_wrapped", {63'd0, w_wrapped}, 64'd1);
            check("t4_busy", {63'd0, w_busy}, 64'd1);
        end
        check("t4_count", {54'd0, w_wcount}, 64'd3);
        check("t4_done",  {63'd0, w_done},   64'd0);

        // Test 5: LENGTH=0 means 512 words
        do_reset();
        a_valid = 1;
        do_start(10'd0);
        for (int i = 0; i < 512; i++) begin
            a_data = 32'h1000 + i;
            tick();
            check("t5_addr", {54'd0, wren, addr}, 64'(32'h200 + i));
        end
        check("t5_data",  {32'd0, data},    64'h11FF);
        check("t5_done",  {63'd0, done},    64'd1);
        check("t5_count", {54'd0, wcount},  64'd512);
        check("t5_ready", {63'd0, a_ready}, 64'd0);
        tick();
        check("t5_no_513th", {63'd0, wren}, 64'd0);

        // Test 6: ABORT and START together during capture
        do_reset();
        a_valid = 1;
        do_start(10'd8);
        a_data = 32'h30;
        tick();
        a_data = 32'h31;
        tick();
        abort = 1; start = 1; a_data = 32'h32;
        #1;
        check("t6_aready_abort", {63'd0, a_ready}, 64'd0);
        check("t6_pending_wren", {63'd0, wren},    64'd1);
        check("t6_pending_data", {32'd0, data},    64'h31);
        tick();
        abort = 0; start = 0;
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_done", {63'd0, done}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_wren", {63'd0, wren},    64'd0);
            check("t6_ready0",  {63'd0, a_ready}, 64'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
